chacha_block_core: RTL and testbench



---
 rtl/chacha_pkg.sv | 42 ++++
 rtl/chacha_qr.sv | 33 +++
 rtl/chacha_block_core.sv | 151 +++++++++++++++
 tb/tb_chacha_block_core.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared types, constants and helpers for the ChaCha block core.
// Word 0 of a state_t sits in the low 32 bits, so a state packs directly onto a 512-bit bus.
package chacha_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [15:0]      state_t;

    localparam word_t SIGMA0 = 32'h61707865;
    localparam word_t SIGMA1 = 32'h3320646e;
    localparam word_t SIGMA2 = 32'h79622d32;
    localparam word_t SIGMA3 = 32'h6b206574;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    function automatic state_t init_state(
        input logic [8*WORD_W-1:0] key,
        input logic [3*WORD_W-1:0] nonce,
        input word_t               counter
    );
        state_t s;
        s[0]     = SIGMA0;
        s[1]     = SIGMA1;
        s[2]     = SIGMA2;
        s[3]     = SIGMA3;
        s[11:4]  = key;
        s[12]    = counter;
        s[15:13] = nonce;
        return s;
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter round on four words (rotations 16/12/8/7).
module chacha_qr
    import chacha_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  word_t c,
    input  word_t d,
    output word_t a_next,
    output word_t b_next,
    output word_t c_next,
    output word_t d_next
);

    word_t a1_s, b1_s, c1_s, d1_s;
    word_t a2_s, b2_s, c2_s, d2_s;

    assign a1_s = a + b;
    assign d1_s = rotl(d ^ a1_s, 32'd16);
    assign c1_s = c + d1_s;
    assign b1_s = rotl(b ^ c1_s, 32'd12);

    assign a2_s = a1_s + b1_s;
    assign d2_s = rotl(d1_s ^ a2_s, 32'd8);
    assign c2_s = c1_s + d2_s;
    assign b2_s = rotl(b1_s ^ c2_s, 32'd7);

    assign a_next = a2_s;
    assign b_next = b2_s;
    assign c_next = c2_s;
    assign d_next = d2_s;

endmodule

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: one column or diagonal half-round per clock,
// final feed-forward add, and a held keystream block until the consumer takes it.
module chacha_block_core
    import chacha_pkg::*;
#(
    parameter int ROUNDS       = 20,
    parameter int CTR_AUTO_INC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_cont,
    input  logic [255:0] in_key,
    input  logic [95:0]  in_nonce,
    input  logic [31:0]  in_counter,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_block,
    output logic         busy
);

    localparam int                CNT_W    = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
    localparam logic [CNT_W-1:0]  LAST_RND = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(32'd1);

    if ((ROUNDS < 2) || ((ROUNDS % 2) != 0)) begin : g_rounds_check
        $error("chacha_block_core: ROUNDS must be even and >= 2");
    end

    fsm_t             state_r;
    logic [CNT_W-1:0] round_cnt_r;
    state_t           init_r;
    state_t           work_r;
    state_t           out_block_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             ctx_valid_r;

    state_t           start_s;
    state_t           work_next_s;
    logic             diag_s;
    word_t            q_in_s  [4][4];
    word_t            q_out_s [4][4];

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_block = out_block_r;
    assign busy      = busy_r;
    assign diag_s    = round_cnt_r[0];

    // Initial state for a request; a continuation with no prior request uses all-zero key/nonce/counter
    always_comb begin
        start_s = '0;
        if ((CTR_AUTO_INC != 0) && in_cont) begin
            if (ctx_valid_r) begin
                start_s = init_state(init_r[11:4], init_r[15:13], init_r[12] + 32'd1);
            end else begin
                start_s = init_state(256'd0, 96'd0, 32'd0);
            end
        end else begin
            start_s = init_state(in_key, in_nonce, in_counter);
        end
    end

    // Lane l takes row r from column l, or from column (l+r)%4 on diagonal rounds
    for (genvar l = 0; l < 4; l++) begin : g_lane
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign q_in_s[l][r] = diag_s ? work_r[r*4 + ((l + r) % 4)] : work_r[r*4 + l];
        end

        chacha_qr u_qr (
            .a      (q_in_s[l][0]),
            .b      (q_in_s[l][1]),
            .c      (q_in_s[l][2]),
            .d      (q_in_s[l][3]),
            .a_next (q_out_s[l][0]),
            .b_next (q_out_s[l][1]),
            .c_next (q_out_s[l][2]),
            .d_next (q_out_s[l][3])
        );
    end

    // Scatter lane results back: word w (row w/4, column w%4) came from the inverse lane mapping
    for (genvar w = 0; w < 16; w++) begin : g_word
        localparam int ROW    = w / 4;
        localparam int COL_LN = w % 4;
        localparam int DIA_LN = ((w % 4) - (w / 4) + 4) % 4;
        assign work_next_s[w] = diag_s ? q_out_s[DIA_LN][ROW] : q_out_s[COL_LN][ROW];
    end

    // Control FSM with registered handshake outputs and the round datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            round_cnt_r <= '0;
            init_r      <= '0;
            work_r      <= '0;
            out_block_r <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            ctx_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        init_r      <= start_s;
                        work_r      <= start_s;
                        round_cnt_r <= '0;
                        ctx_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ROUND;
                    end
                end
                ROUND: begin
                    work_r <= work_next_s;
                    if (round_cnt_r == LAST_RND) begin
                        state_r <= FINAL;
                    end else begin
                        round_cnt_r <= round_cnt_r + CNT_ONE;
                    end
                end
                FINAL: begin
                    for (int i = 0; i < 16; i++) begin
                        out_block_r[i] <= work_r[i] + init_r[i];
                    end
                    out_valid_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_block_core.sv
// Self-checking bench: known-answer table, handshake corner sequences and randomized
// requests on ROUNDS=20/12/8 instances checked against a plain ChaCha reference model.
module tb_chacha_block_core;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   in_valid_v, in_ready_v, out_valid_v, out_ready_v, busy_v;
    logic         in_cont;
    logic [255:0] in_key;
    logic [95:0]  in_nonce;
    logic [31:0]  in_counter;
    logic [511:0] blk0, blk1, blk2;
    logic [31:0]  qa, qb, qc, qd, qa_n, qb_n, qc_n, qd_n;

    int checks = 0;
    int errors = 0;

    logic [255:0] ctx_key   [3];
    logic [95:0]  ctx_nonce [3];
    logic [31:0]  ctx_ctr   [3];
    bit           ctx_ok    [3];

    always #5 clk = ~clk;

    chacha_block_core #(.ROUNDS(20), .CTR_AUTO_INC(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_cont(in_cont), .in_key(in_key), .in_nonce(in_nonce), .in_counter(in_counter),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_block(blk0), .busy(busy_v[0])
    );
    chacha_block_core #(.ROUNDS(12), .CTR_AUTO_INC(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_cont(in_cont), .in_key(in_key), .in_nonce(in_nonce), .in_counter(in_counter),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_block(blk1), .busy(busy_v[1])
    );
    chacha_block_core #(.ROUNDS(8), .CTR_AUTO_INC(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_cont(in_cont), .in_key(in_key), .in_nonce(in_nonce), .in_counter(in_counter),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_block(blk2), .busy(busy_v[2])
    );
    chacha_qr u_qr (
        .a(qa), .b(qb), .c(qc), .d(qd),
        .a_next(qa_n), .b_next(qb_n), .c_next(qc_n), .d_next(qd_n)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int rounds_of(input int d);
        return (d == 0) ? 20 : ((d == 1) ? 12 : 8);
    endfunction

    function automatic logic [511:0] blk_of(input int d);
        case (d)
            0:       return blk0;
            1:       return blk1;
            default: return blk2;
        endcase
    endfunction

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Textbook ChaCha block: alternating column/diagonal rounds over index quads, then feed-forward
    function automatic logic [511:0] ref_block(input logic [255:0] key, input logic [95:0] nonce,
                                               input logic [31:0] ctr, input int rounds);
        logic [31:0]  x [16];
        logic [31:0]  s [16];
        logic [511:0] res;
        int qi [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                          '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = key[32*i +: 32];
        s[12] = ctr;
        for (int i = 0; i < 3; i++) s[13 + i] = nonce[32*i +: 32];
        x = s;
        for (int r = 0; r < rounds; r++) begin
            for (int q = 0; q < 4; q++) begin
                int a, b, c, d;
                a = qi[(r % 2) * 4 + q][0]; b = qi[(r % 2) * 4 + q][1];
                c = qi[(r % 2) * 4 + q][2]; d = qi[(r % 2) * 4 + q][3];
                x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 7);
            end
        end
        for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + s[i];
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ctx_key[i] = '0; ctx_nonce[i] = '0; ctx_ctr[i] = '0; ctx_ok[i] = 1'b0;
        end
    endtask

    // Scoreboard view of a request: continuation reuses the last key/nonce with counter+1
    task automatic model_req(input int d, input bit cont, input logic [255:0] k,
                             input logic [95:0] n, input logic [31:0] c, output logic [511:0] exp);
        logic [255:0] kk;
        logic [95:0]  nn;
        logic [31:0]  cc;
        if (cont) begin
            if (ctx_ok[d]) begin
                kk = ctx_key[d]; nn = ctx_nonce[d]; cc = ctx_ctr[d] + 32'd1;
            end else begin
                kk = '0; nn = '0; cc = '0;
            end
        end else begin
            kk = k; nn = n; cc = c;
        end
        ctx_key[d] = kk; ctx_nonce[d] = nn; ctx_ctr[d] = cc; ctx_ok[d] = 1'b1;
        exp = ref_block(kk, nn, cc, rounds_of(d));
    endtask

    // One request on instance d with out_ready high; returns the block and accept-to-valid latency
    task automatic run_block(input int d, input bit cont, input logic [255:0] k, input logic [95:0] n,
                             input logic [31:0] c, output logic [511:0] got, output int lat);
        int w;
        bit bad;
        @(negedge clk);
        in_cont = cont; in_key = k; in_nonce = n; in_counter = c;
        in_valid_v[d] = 1'b1; out_ready_v[d] = 1'b1;
        w = 0;
        while (in_ready_v[d] !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check("accept_timeout", 512'(in_ready_v[d]), 512'd1);
        @(negedge clk);
        in_valid_v[d] = 1'b0;
        in_key = {8{$urandom()}}; in_nonce = {3{$urandom()}}; in_counter = $urandom();
        in_cont = 1'($urandom_range(0, 1));
        lat = 0; bad = 1'b0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (in_ready_v[d] !== 1'b0) bad = 1'b1;
            if (out_valid_v[d] === 1'b1) break;
            if (busy_v[d] !== 1'b1) bad = 1'b1;
        end
        if (busy_v[d] !== 1'b0) bad = 1'b1;
        got = blk_of(d);
        check("ready_busy_during_block", 512'(bad), 512'd0);
        @(negedge clk);
        check("idle_after_handshake", 512'({out_valid_v[d], in_ready_v[d]}), 512'(2'b01));
    endtask

    typedef struct {
        int           d;
        bit           cont;
        logic [255:0] key;
        logic [95:0]  nonce;
        logic [31:0]  ctr;
        bit           kat;
        logic [31:0]  s0;
        logic [31:0]  s1;
        logic [31:0]  s15;
    } vec_t;

    vec_t         tbl [9];
    logic [511:0] res [9];
    logic [255:0] rfc_key;
    logic [95:0]  rfc_nonce;
    logic [511:0] exp_b, got_b, snap;
    int           lat;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
        rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
        tbl[0] = '{0, 1'b0, rfc_key, rfc_nonce, 32'd1, 1'b1, 32'he4e7f110, 32'h15593bd1, 32'h4e3c50a2};
        tbl[1] = '{0, 1'b1, {8{32'hdeadbeef}}, {3{32'h12345678}}, 32'h55, 1'b0, 32'd0, 32'd0, 32'd0};
        tbl[2] = '{0, 1'b0, rfc_key, rfc_nonce, 32'd2, 1'b0, 32'd0, 32'd0, 32'd0};
        tbl[3] = '{0, 1'b0, rfc_key, rfc_nonce, 32'hffffffff, 1'b0, 32'd0, 32'd0, 32'd0};
        tbl[4] = '{0, 1'b1, '0, '0, 32'h7, 1'b0, 32'd0, 32'd0, 32'd0};
        tbl[5] = '{1, 1'b0, rfc_key, rfc_nonce, 32'hffffffff, 1'b0, 32'd0, 32'd0, 32'd0};
        tbl[6] = '{1, 1'b1, '0, '0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0};
        tbl[7] = '{2, 1'b0, ~rfc_key, rfc_nonce, 32'hffffffff, 1'b0, 32'd0, 32'd0, 32'd0};
        tbl[8] = '{2, 1'b1, '0, '0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0};

        rst = 1'b1; in_valid_v = 3'b000; out_ready_v = 3'b111;
        in_cont = 1'b0; in_key = '0; in_nonce = '0; in_counter = '0;
        qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_handshake", 512'({in_ready_v, out_valid_v, busy_v}), 512'({3'b111, 3'b000, 3'b000}));
        check("reset_block", blk0, 512'd0);
        check("qr_vector", 512'({qa_n, qb_n, qc_n, qd_n}),
              512'({32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb}));
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            model_req(tbl[i].d, tbl[i].cont, tbl[i].key, tbl[i].nonce, tbl[i].ctr, exp_b);
            run_block(tbl[i].d, tbl[i].cont, tbl[i].key, tbl[i].nonce, tbl[i].ctr, got_b, lat);
            res[i] = got_b;
            check($sformatf("tbl%0d_block", i), got_b, exp_b);
            check($sformatf("tbl%0d_latency", i), 512'(lat), 512'(rounds_of(tbl[i].d) + 1));
            if (tbl[i].kat) begin
                check("kat_s0_s1_s15", 512'({got_b[31:0], got_b[63:32], got_b[511:480]}),
                      512'({tbl[i].s0, tbl[i].s1, tbl[i].s15}));
            end
        end
        check("cont_equals_ctr2", res[1], res[2]);
        check("wrap_r20", res[4], ref_block(rfc_key, rfc_nonce, 32'h0, 20));
        check("wrap_r12", res[6], ref_block(rfc_key, rfc_nonce, 32'h0, 12));
        check("wrap_r8", res[8], ref_block(~rfc_key, rfc_nonce, 32'h0, 8));

        // Backpressure: block held for 10 cycles while a competing request is offered
        model_req(0, 1'b0, {8{32'hcafef00d}}, {3{32'h0badf00d}}, 32'h1234, exp_b);
        @(negedge clk);
        in_cont = 1'b0; in_key = {8{32'hcafef00d}}; in_nonce = {3{32'h0badf00d}}; in_counter = 32'h1234;
        in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b0;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        for (int w = 0; w < 100 && out_valid_v[0] !== 1'b1; w++) @(negedge clk);
        snap = blk0;
        check("bp_block", snap, exp_b);
        in_key = {8{32'h77777777}}; in_counter = 32'h99;
        for (int c = 0; c < 10; c++) begin
            in_valid_v[0] = 1'b1;
            @(negedge clk);
            check("bp_hold_flags", 512'({out_valid_v[0], in_ready_v[0], busy_v[0]}), 512'(3'b100));
            check("bp_hold_block", blk0, snap);
        end
        in_valid_v[0] = 1'b0; out_ready_v[0] = 1'b1;
        @(negedge clk);
        check("bp_release", 512'({out_valid_v[0], in_ready_v[0], busy_v[0]}), 512'(3'b010));
        model_req(0, 1'b1, '0, '0, 32'd0, exp_b);
        run_block(0, 1'b1, '0, '0, 32'd0, got_b, lat);
        check("bp_then_cont", got_b, exp_b);

        // Reset during ROUND with round_cnt at 7, then recover
        @(negedge clk);
        in_cont = 1'b0; in_key = rfc_key; in_nonce = rfc_nonce; in_counter = 32'd1;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midreset_flags", 512'({in_ready_v[0], out_valid_v[0], busy_v[0]}), 512'(3'b100));
        check("midreset_block", blk0, 512'd0);
        model_req(1, 1'b1, rfc_key, rfc_nonce, 32'd5, exp_b);
        run_block(1, 1'b1, rfc_key, rfc_nonce, 32'd5, got_b, lat);
        check("cont_after_reset_zero", got_b, exp_b);
        model_req(0, 1'b0, rfc_key, rfc_nonce, 32'd1, exp_b);
        run_block(0, 1'b0, rfc_key, rfc_nonce, 32'd1, got_b, lat);
        check("midreset_recover_kat", 512'({got_b[31:0], got_b[63:32], got_b[511:480]}),
              512'({32'he4e7f110, 32'h15593bd1, 32'h4e3c50a2}));
        check("midreset_recover_block", got_b, exp_b);

        // Randomized requests across all three round counts
        for (int i = 0; i < 24; i++) begin
            int           d;
            bit           cont;
            logic [255:0] k;
            logic [95:0]  n;
            logic [31:0]  c;
            d = $urandom_range(0, 2);
            cont = ($urandom_range(0, 2) == 0);
            k = {8{$urandom()}} ^ {$urandom(), $urandom(), $urandom(), $urandom(),
                                   $urandom(), $urandom(), $urandom(), $urandom()};
            n = {$urandom(), $urandom(), $urandom()};
            c = ($urandom_range(0, 3) == 0) ? 32'hffffffff : 32'($urandom());
            model_req(d, cont, k, n, c, exp_b);
            run_block(d, cont, k, n, c, got_b, lat);
            check($sformatf("rand%0d_block", i), got_b, exp_b);
            check($sformatf("rand%0d_latency", i), 512'(lat), 512'(rounds_of(d) + 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
